mant_scheduler: RTL and testbench

MANT_SCHEDULER -- requirements
Module: mant_scheduler

---
 rtl/mant_pkg.sv | 21 ++
 rtl/mant_timer.sv | 29 ++
 rtl/mant_scheduler.sv | 146 ++++++++++++++
 tb/tb_mant_scheduler.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mant_pkg.sv
// Shared definitions for the maintenance scheduler: FSM state encoding,
// default handshake parameters and the effective-period helper.
package mant_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    WAIT_PERIOD = 3'd1,
    REQUEST     = 3'd2,
    WAIT_ACK    = 3'd3,
    ALARM       = 3'd4
  } mant_state_e;

  localparam int DEF_ACK_TIMEOUT = 4;
  localparam int DEF_MAX_RETRY   = 3;

  // A programmed period of zero behaves like a period of one cycle.
  function automatic logic [7:0] eff_period(input logic [7:0] p);
    return (p == 8'd0) ? 8'd1 : p;
  endfunction

endpackage

// File: rtl/mant_timer.sv
// Loadable down-counter. Load wins over decrement; the count holds at zero.
// The expiry flag marks the last cycle of a countdown (count equal to 1).
module mant_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         dec,
  output logic         expired
);

  logic [W-1:0] count_reg;

  // Count register: load a new value or step down towards zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= value;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign expired = (count_reg == W'(1));

endmodule

// File: rtl/mant_scheduler.sv
// Periodic maintenance scheduler: issues a one-cycle request pulse every
// period, waits for an acknowledge with bounded retries, and latches an
// alarm on handshake failure or machine error until cleared.
module mant_scheduler
  import mant_pkg::*;
#(
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT,
  parameter int MAX_RETRY   = DEF_MAX_RETRY
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  input  logic [7:0] period,
  input  logic       enable_mant,
  input  logic       mux_error,
  output logic       m,
  output logic [7:0] mant_count,
  output logic       alarm,
  output logic [2:0] state_o
);

  localparam logic [3:0] ACK_LOAD    = 4'(ACK_TIMEOUT);
  localparam logic [2:0] RETRY_LIMIT = 3'(MAX_RETRY);

  mant_state_e state_reg, state_next;
  logic [2:0]  retry_reg, retry_next;
  logic [7:0]  count_reg, count_next;

  logic       per_load, per_dec, per_expired;
  logic [7:0] per_value;
  logic       ack_load, ack_dec, ack_expired;

  mant_timer #(.W(8)) u_period_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (per_load),
    .value   (per_value),
    .dec     (per_dec),
    .expired (per_expired)
  );

  mant_timer #(.W(4)) u_ack_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (ack_load),
    .value   (ACK_LOAD),
    .dec     (ack_dec),
    .expired (ack_expired)
  );

  // State, retry and maintenance-count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      retry_reg <= '0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      retry_reg <= retry_next;
      count_reg <= count_next;
    end
  end

  // Next-state and timer control; machine error outranks everything but IDLE.
  always_comb begin
    state_next = state_reg;
    retry_next = retry_reg;
    count_next = count_reg;
    per_load   = 1'b0;
    per_value  = eff_period(period);
    per_dec    = 1'b0;
    ack_load   = 1'b0;
    ack_dec    = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (en) begin
          per_load   = 1'b1;
          state_next = WAIT_PERIOD;
        end
      end

      WAIT_PERIOD: begin
        if (mux_error) begin
          state_next = ALARM;
        end else if (!en) begin
          // Drop the pending period so nothing stale survives in IDLE.
          per_load   = 1'b1;
          per_value  = '0;
          state_next = IDLE;
        end else if (per_expired) begin
          state_next = REQUEST;
        end else begin
          per_dec = 1'b1;
        end
      end

      REQUEST: begin
        if (mux_error) begin
          state_next = ALARM;
        end else begin
          ack_load   = 1'b1;
          state_next = WAIT_ACK;
        end
      end

      WAIT_ACK: begin
        if (mux_error) begin
          state_next = ALARM;
        end else if (enable_mant) begin
          count_next = (count_reg != 8'hFF) ? count_reg + 8'd1 : count_reg;
          retry_next = '0;
          per_load   = 1'b1;
          state_next = WAIT_PERIOD;
        end else if (ack_expired) begin
          if (retry_reg < RETRY_LIMIT) begin
            retry_next = retry_reg + 3'd1;
            state_next = REQUEST;
          end else begin
            state_next = ALARM;
          end
        end else begin
          ack_dec = 1'b1;
        end
      end

      ALARM: begin
        if (clr) begin
          retry_next = '0;
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign m          = (state_reg == REQUEST);
  assign alarm      = (state_reg == ALARM);
  assign state_o    = state_reg;
  assign mant_count = count_reg;

endmodule

// File: tb/tb_mant_scheduler.sv
// Self-checking bench for mant_scheduler: directed scenarios followed by
// randomized traffic, all compared against a phase/elapsed-time model
// through an expectation queue drained by an independent monitor.
module tb_mant_scheduler;

  localparam int ACK_T = 4;
  localparam int MAX_R = 3;

  localparam int P_IDLE  = 0;
  localparam int P_WAIT  = 1;
  localparam int P_REQ   = 2;
  localparam int P_ACK   = 3;
  localparam int P_ALARM = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] period = 8'd0;
  logic       enable_mant = 1'b0;
  logic       mux_error = 1'b0;
  logic       m;
  logic [7:0] mant_count;
  logic       alarm;
  logic [2:0] state_o;

  always #5 clk = ~clk;

  mant_scheduler #(.ACK_TIMEOUT(ACK_T), .MAX_RETRY(MAX_R)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .clr         (clr),
    .period      (period),
    .enable_mant (enable_mant),
    .mux_error   (mux_error),
    .m           (m),
    .mant_count  (mant_count),
    .alarm       (alarm),
    .state_o     (state_o)
  );

  typedef struct {
    logic       m;
    logic       alarm;
    logic [2:0] st;
    logic [7:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   m_times[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;

  // Reference model: current phase, cycles spent in it, its length target,
  // request pulses issued in this maintenance attempt, acknowledged count.
  int ph, elapsed, target, pulses, cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    ph = P_IDLE; elapsed = 0; target = 0; pulses = 0; cnt = 0;
  endfunction

  function automatic void model_edge(bit e, bit c, bit a, bit x, logic [7:0] p);
    int pe;
    pe = (p == 8'd0) ? 1 : int'(p);
    case (ph)
      P_IDLE:  if (e) begin ph = P_WAIT; target = pe; elapsed = 0; end
      P_WAIT: begin
        if (x) ph = P_ALARM;
        else if (!e) ph = P_IDLE;
        else begin
          elapsed++;
          if (elapsed == target) ph = P_REQ;
        end
      end
      P_REQ: begin
        if (x) ph = P_ALARM;
        else begin pulses++; ph = P_ACK; elapsed = 0; end
      end
      P_ACK: begin
        if (x) ph = P_ALARM;
        else if (a) begin
          if (cnt < 255) cnt++;
          pulses = 0; ph = P_WAIT; target = pe; elapsed = 0;
        end else begin
          elapsed++;
          if (elapsed == ACK_T) ph = (pulses < MAX_R + 1) ? P_REQ : P_ALARM;
        end
      end
      default: if (c) begin ph = P_IDLE; pulses = 0; end
    endcase
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.m = (ph == P_REQ);
    e.alarm = (ph == P_ALARM);
    e.st = 3'(ph);
    e.cnt = 8'(cnt);
    return e;
  endfunction

  // One clock of stimulus: drive at the falling edge, predict the next edge.
  task automatic step(input bit e, input bit c, input bit a, input bit x,
                      input logic [7:0] p, input bit r);
    @(negedge clk);
    en = e; clr = c; enable_mant = a; mux_error = x; period = p;
    if (r) begin
      rst = 1'b1;
      #1;
      chk("rst_now_m", m, 0);
      chk("rst_now_state", state_o, 0);
      chk("rst_now_count", mant_count, 0);
      chk("rst_now_alarm", alarm, 0);
      model_reset();
    end else begin
      rst = 1'b0;
      model_edge(e, c, a, x, p);
    end
    exp_q.push_back(model_out());
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: one expectation per rising edge, compared just after the edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (m === 1'b1) m_times.push_back(cyc);
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("m", m, mon_e.m);
      chk("alarm", alarm, mon_e.alarm);
      chk("state", state_o, mon_e.st);
      chk("count", mant_count, mon_e.cnt);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    step(0, 0, 0, 0, 8'd0, 1);
    step(0, 0, 0, 0, 8'd0, 1);
    step(0, 0, 0, 0, 8'd0, 0);

    // Period 5 with ack one cycle after each pulse.
    m_times.delete();
    for (int i = 0; i < 80 && cnt < 3; i++) step(1, 0, (ph == P_ACK), 0, 8'd5, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 8'd5, 0);
    settle();
    chk("p5_count", mant_count, 3);
    chk("p5_idle", state_o, P_IDLE);
    chk("p5_pulses", m_times.size(), 3);
    for (int i = 1; i < m_times.size(); i++) chk("p5_spacing", m_times[i] - m_times[i-1], 7);

    // Period 0 behaves as period 1.
    step(0, 0, 0, 0, 8'd0, 1);
    m_times.delete();
    for (int i = 0; i < 20; i++) step(1, 0, (ph == P_ACK), 0, 8'd0, 0);
    settle();
    chk("p0_pulses_seen", (m_times.size() >= 2), 1);
    for (int i = 1; i < m_times.size(); i++) chk("p0_spacing", m_times[i] - m_times[i-1], 3);

    // No acknowledge: four pulses five cycles apart, then alarm until clr.
    step(0, 0, 0, 0, 8'd0, 1);
    m_times.delete();
    for (int i = 0; i < 40; i++) step(1, 0, 0, 0, 8'd2, 0);
    settle();
    chk("noack_pulses", m_times.size(), 4);
    for (int i = 1; i < m_times.size(); i++) chk("noack_spacing", m_times[i] - m_times[i-1], 5);
    chk("noack_alarm", alarm, 1);
    chk("noack_state", state_o, P_ALARM);
    step(0, 1, 0, 0, 8'd2, 0);
    step(0, 0, 0, 0, 8'd2, 0);
    settle();
    chk("clr_state", state_o, P_IDLE);
    chk("clr_alarm", alarm, 0);

    // Ack and error together in WAIT_ACK: error wins, count unchanged.
    step(0, 0, 0, 0, 8'd0, 1);
    for (int i = 0; i < 30 && cnt < 1; i++) step(1, 0, (ph == P_ACK), 0, 8'd1, 0);
    for (int i = 0; i < 30 && ph != P_ACK; i++) step(1, 0, 0, 0, 8'd1, 0);
    settle();
    chk("err_in_wait_ack", state_o, P_ACK);
    step(1, 0, 1, 1, 8'd1, 0);
    settle();
    chk("err_state", state_o, P_ALARM);
    chk("err_alarm", alarm, 1);
    chk("err_count", mant_count, 1);

    // Reset while the request pulse is high.
    step(0, 0, 0, 0, 8'd0, 1);
    for (int i = 0; i < 30 && cnt < 1; i++) step(1, 0, (ph == P_ACK), 0, 8'd2, 0);
    for (int i = 0; i < 30 && ph != P_REQ; i++) step(1, 0, 0, 0, 8'd2, 0);
    settle();
    chk("rst_pulse_high", m, 1);
    step(1, 0, 0, 0, 8'd2, 1);
    step(0, 0, 0, 0, 8'd2, 0);

    // en dropped during WAIT_ACK, then acknowledged.
    for (int i = 0; i < 30 && ph != P_ACK; i++) step(1, 0, 0, 0, 8'd3, 0);
    step(0, 0, 0, 0, 8'd3, 0);
    step(0, 0, 1, 0, 8'd3, 0);
    settle();
    chk("endrop_state", state_o, P_WAIT);
    chk("endrop_count", mant_count, 1);
    step(0, 0, 0, 0, 8'd3, 0);
    settle();
    chk("endrop_idle", state_o, P_IDLE);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      bit e, c, a, x, r;
      e = ($urandom_range(0, 9) != 0);
      c = (ph == P_ALARM) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
      a = (ph == P_ACK) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      x = ($urandom_range(0, 49) == 0);
      r = ($urandom_range(0, 299) == 0);
      step(e, c, a, x, 8'($urandom_range(0, 3)), r);
    end

    settle();
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
